// File: rtl/dbg_reg_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dbg_reg_fifo_if                                            |
// | Description : Bus bundle for dbg_reg_fifo. Carries the debug-write       |
// |               strobe from the core and the valid/ready drain port to the |
// |               host/UART bridge.                                          |
// |               Optional macro DBG_TIMESTAMP_EN adds the rd_ts head        |
// |               timestamp signal.                                          |
// | Ports       : master - producer/consumer side (drives wr_*, rd_ready)    |
// |               slave  - FIFO side (drives rd_valid, rd_ch, rd_data[,ts])  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface dbg_reg_fifo_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
`ifdef DBG_TIMESTAMP_EN
  logic [15:0]       rd_ts;
`endif

`ifdef DBG_TIMESTAMP_EN
  modport master (
    output wr_en, wr_ch, wr_data, rd_ready,
    input  rd_valid, rd_ch, rd_data, rd_ts
  );
  modport slave (
    input  wr_en, wr_ch, wr_data, rd_ready,
    output rd_valid, rd_ch, rd_data, rd_ts
  );
`else
  modport master (
    output wr_en, wr_ch, wr_data, rd_ready,
    input  rd_valid, rd_ch, rd_data
  );
  modport slave (
    input  wr_en, wr_ch, wr_data, rd_ready,
    output rd_valid, rd_ch, rd_data
  );
`endif
endinterface
`default_nettype wire

// File: rtl/dbg_reg_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dbg_reg_fifo                                               |
// | Description : Multi-channel debug-register capture FIFO. Every debug     |
// |               write is tagged with a channel and queued for a host       |
// |               drain port (show-ahead, valid/ready). A per-channel        |
// |               "latest value" shadow feeds a registered display output.   |
// |               Optional macro DBG_TIMESTAMP_EN stores a 16-bit cycle      |
// |               timestamp with each entry and presents it on bus.rd_ts.    |
// | Ports       : clk       - system clock, rising edge                      |
// |               reset     - asynchronous active-high, clears all state     |
// |               bus       - dbg_reg_fifo_if.slave (write strobe, drain)    |
// |               count     - occupancy 0..DEPTH                             |
// |               overflow  - sticky, a write was dropped while full         |
// |               clr_ovf   - clears overflow (a new drop wins)              |
// |               disp_sel  - shadow register selected for display           |
// |               disp_data - registered copy of shadow[disp_sel]            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dbg_reg_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CH_W   = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  dbg_reg_fifo_if.slave              bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  wire logic                  clr_ovf,
  input  wire logic [CH_W-1:0]       disp_sel,
  output logic [DATA_W-1:0]          disp_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NCH   = 1 << CH_W;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  // Pointer and occupancy state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;

  // Entry storage (not reset: contents are only observed while count != 0)
  logic [CH_W-1:0]   ch_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  // Per-channel latest value and its display register
  logic [DATA_W-1:0] shadow_q [NCH];
  logic [DATA_W-1:0] disp_q;

  logic empty;
  logic full;
  logic push;
  logic pop;

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == c_depth);
    pop      = !empty && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = bus.wr_en && (!full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // A dropped write outranks a simultaneous clear.
    if (bus.wr_en && !push) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ch_mem_q[wr_ptr_q]   <= bus.wr_ch;
      data_mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Shadows follow every write, even one the FIFO drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
      end
      disp_q <= '0;
    end else begin
      if (bus.wr_en) begin
        shadow_q[bus.wr_ch] <= bus.wr_data;
      end
      disp_q <= shadow_q[disp_sel];
    end
  end

  // ------------------------------------------------------------------------
  // Optional per-entry timestamp
  // ------------------------------------------------------------------------
`ifdef DBG_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
    end
  end

  // Stores the counter value present at the push edge.
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign bus.rd_ts = empty ? '0 : ts_mem_q[rd_ptr_q];
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  // Head fields are forced to zero when empty so stale storage (e.g. after a
  // mid-stream reset) never leaks onto the drain port.
  assign bus.rd_valid = !empty;
  assign bus.rd_ch    = empty ? '0 : ch_mem_q[rd_ptr_q];
  assign bus.rd_data  = empty ? '0 : data_mem_q[rd_ptr_q];

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign disp_data = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_reg_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dbg_reg_fifo                                            |
// | Description : Self-checking bench for dbg_reg_fifo. A queue-based        |
// |               reference holds expected entries; heads are compared when  |
// |               the DUT hands them over. Covers DBG_TIMESTAMP_EN if set.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dbg_reg_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [15:0]       ts;
  } ent_t;

  logic              clk;
  logic              reset;
  logic              clr_ovf;
  logic [CH_W-1:0]   disp_sel;
  logic [3:0]        count;
  logic              overflow;
  logic [DATA_W-1:0] disp_data;

  dbg_reg_fifo_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  dbg_reg_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .disp_sel  (disp_sel),
    .disp_data (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT timestamp at each edge.
  logic [15:0] tb_cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 16'd1;
  end

  // Reference state
  ent_t              sb[$];
  logic [DATA_W-1:0] shadow_m [1 << CH_W];
  logic              ovf_m;
  logic [DATA_W-1:0] disp_m;

  int n_cmp;
  int n_err;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < (1 << CH_W); i++) shadow_m[i] = '0;
    ovf_m  = 1'b0;
    disp_m = '0;
  endtask

  task automatic check_state();
    chk_val("count", 64'(count), 64'(sb.size()));
    chk_val("rd_valid", 64'(bus.rd_valid), 64'(sb.size() != 0));
    chk_val("overflow", 64'(overflow), 64'(ovf_m));
    chk_val("disp_data", 64'(disp_data), 64'(disp_m));
    if (sb.size() == 0) begin
      chk_val("empty_data", 64'(bus.rd_data), 64'd0);
    end
  endtask

  // One clock: drive inputs now (posedge+1), advance, update model, check.
  task automatic cycle(input logic we, input logic [CH_W-1:0] ch,
                       input logic [DATA_W-1:0] d, input logic rr, input logic clr);
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] disp_next;
    ent_t              e;
    ent_t              h;
    bus.wr_en   = we;
    bus.wr_ch   = ch;
    bus.wr_data = d;
    bus.rd_ready = rr;
    clr_ovf     = clr;
    pop       = (sb.size() != 0) && rr;
    push      = we && ((sb.size() < DEPTH) || pop);
    disp_next = shadow_m[disp_sel];
    e.ch   = ch;
    e.data = d;
    e.ts   = tb_cyc;
    if (pop) begin
      chk_val("pop_ch", 64'(bus.rd_ch), 64'(sb[0].ch));
      chk_val("pop_data", 64'(bus.rd_data), 64'(sb[0].data));
`ifdef DBG_TIMESTAMP_EN
      chk_val("pop_ts", 64'(bus.rd_ts), 64'(sb[0].ts));
`endif
    end
    @(posedge clk);
    if (pop) h = sb.pop_front();
    if (push) sb.push_back(e);
    if (we) shadow_m[ch] = d;
    if (we && !push) ovf_m = 1'b1;
    else if (clr)    ovf_m = 1'b0;
    disp_m = disp_next;
    #1;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 2 * DEPTH + 4) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      guard++;
    end
    chk_val("drain_done", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    clr_ovf = 1'b0; disp_sel = '0;
    model_clear();
    do_reset();
    chk_val("rst_count", 64'(count), 64'd0);
    chk_val("rst_valid", 64'(bus.rd_valid), 64'd0);

    // Single push, show-ahead head and 2-cycle display latency
    disp_sel = 2'd1;
    cycle(1'b1, 2'd1, 32'h0000_00A5, 1'b0, 1'b0);
    chk_val("first_valid", 64'(bus.rd_valid), 64'd1);
    chk_val("first_ch", 64'(bus.rd_ch), 64'd1);
    chk_val("first_data", 64'(bus.rd_data), 64'hA5);
    chk_val("first_count", 64'(count), 64'd1);
    chk_val("disp_1cyc", 64'(disp_data), 64'd0);
    idle(1);
    chk_val("disp_2cyc", 64'(disp_data), 64'hA5);
    drain();

    // Fill, overflow on 9th, shadow still updated, clear
    for (int i = 1; i <= 8; i++) cycle(1'b1, CH_W'((i - 1) % 4), 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 32'd9, 1'b0, 1'b0);
    chk_val("full_count", 64'(count), 64'd8);
    chk_val("ovf_set", 64'(overflow), 64'd1);
    chk_val("head_after_ovf", 64'(bus.rd_data), 64'd1);
    disp_sel = 2'd0;
    idle(2);
    chk_val("shadow0_9", 64'(disp_data), 64'd9);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk_val("ovf_clr", 64'(overflow), 64'd0);

    // Push+pop at full
    cycle(1'b1, 2'd3, 32'h55, 1'b1, 1'b0);
    chk_val("pp_count", 64'(count), 64'd8);
    chk_val("pp_ovf", 64'(overflow), 64'd0);
    chk_val("pp_head", 64'(bus.rd_data), 64'd2);
    drain();

    // Pointer wrap: fill 5, drain 5, then 6 more
    for (int i = 0; i < 5; i++) cycle(1'b1, CH_W'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) cycle(1'b1, CH_W'(i), 32'h300 + 32'(i), 1'b0, 1'b0);
    drain();
    chk_val("wrap_valid_low", 64'(bus.rd_valid), 64'd0);

    // Mixed random traffic
    for (int i = 0; i < 300; i++) begin
      disp_sel = CH_W'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), CH_W'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end
    drain();

    // Asynchronous reset mid-cycle at count 3 with overflow set
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, CH_W'(i % 4), 32'h400 + 32'(i + 1), 1'b0, 1'b0);
    disp_sel = 2'd1;
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);
    chk_val("pre_rst_count", 64'(count), 64'd3);
    chk_val("pre_rst_ovf", 64'(overflow), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_val("arst_valid", 64'(bus.rd_valid), 64'd0);
    chk_val("arst_count", 64'(count), 64'd0);
    chk_val("arst_ovf", 64'(overflow), 64'd0);
    chk_val("arst_disp", 64'(disp_data), 64'd0);
    chk_val("arst_data", 64'(bus.rd_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_state();

    // Timestamped pushes at cycles 10 and 14 after reset release
    begin
      int guard;
      guard = 0;
      while (tb_cyc != 16'd10 && guard < 40) begin idle(1); guard++; end
      cycle(1'b1, 2'd2, 32'hA10, 1'b0, 1'b0);
      guard = 0;
      while (tb_cyc != 16'd14 && guard < 40) begin idle(1); guard++; end
      cycle(1'b1, 2'd3, 32'hA14, 1'b0, 1'b0);
    end
`ifdef DBG_TIMESTAMP_EN
    chk_val("ts_first", 64'(bus.rd_ts), 64'd10);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk_val("ts_second", 64'(bus.rd_ts), 64'd14);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
